// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: field decode, condition check, 16-entry register file
// with optional write-back bypass, and the ID/EXE pipeline register.
module id_stage_pipe #(
   parameter int DATA_W        = 32,
   parameter int PC_W          = 32,
   parameter int WB_BYPASS     = 1,
   parameter int RF_INIT_INDEX = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [PC_W-1:0]   if_pc,
   input  logic [31:0]       if_instr,
   input  logic              hazard,
   input  logic              flush,
   input  logic [3:0]        status,
   input  logic              wb_en,
   input  logic [3:0]        wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   output logic              id_ready,
   output logic [3:0]        src1,
   output logic [3:0]        src2,
   output logic              two_src,
   output logic              ex_valid,
   output logic [PC_W-1:0]   ex_pc,
   output logic [3:0]        ex_cmd,
   output logic              ex_mem_r,
   output logic              ex_mem_w,
   output logic              ex_wb_en,
   output logic              ex_b,
   output logic              ex_s,
   output logic [DATA_W-1:0] ex_rn_val,
   output logic [DATA_W-1:0] ex_rm_val,
   output logic              ex_imm,
   output logic [11:0]       ex_shift_op,
   output logic [23:0]       ex_simm24,
   output logic [3:0]        ex_dest,
   output logic [3:0]        ex_src1,
   output logic [3:0]        ex_src2
);

   typedef struct packed {
      logic              valid;
      logic [PC_W-1:0]   pc;
      logic [3:0]        cmd;
      logic              mem_r;
      logic              mem_w;
      logic              wb_en;
      logic              b;
      logic              s;
      logic [DATA_W-1:0] rn_val;
      logic [DATA_W-1:0] rm_val;
      logic              imm;
      logic [11:0]       shift_op;
      logic [23:0]       simm24;
      logic [3:0]        dest;
      logic [3:0]        src1;
      logic [3:0]        src2;
   } ex_t;

   logic [3:0] cond;
   logic [1:0] mode;
   logic       imm_bit;
   logic [3:0] opcode;
   logic       s_bit;
   logic [3:0] rn;
   logic [3:0] rd;
   logic [3:0] rm;

   assign cond    = if_instr[31:28];
   assign mode    = if_instr[27:26];
   assign imm_bit = if_instr[25];
   assign opcode  = if_instr[24:21];
   assign s_bit   = if_instr[20];
   assign rn      = if_instr[19:16];
   assign rd      = if_instr[15:12];
   assign rm      = if_instr[3:0];

   logic [3:0] dec_cmd;
   logic       dec_mem_r;
   logic       dec_mem_w;
   logic       dec_wb_en;
   logic       dec_b;
   logic       dec_s;

   always_comb begin
      dec_cmd   = 4'b0000;
      dec_mem_r = 1'b0;
      dec_mem_w = 1'b0;
      dec_wb_en = 1'b0;
      dec_b     = 1'b0;
      dec_s     = 1'b0;
      case (mode)
         2'b00: begin
            dec_wb_en = 1'b1;
            dec_s     = s_bit;
            case (opcode)
               4'b1101: dec_cmd = 4'b0001;
               4'b1111: dec_cmd = 4'b1001;
               4'b0100: dec_cmd = 4'b0010;
               4'b0101: dec_cmd = 4'b0011;
               4'b0010: dec_cmd = 4'b0100;
               4'b0110: dec_cmd = 4'b0101;
               4'b0000: dec_cmd = 4'b0110;
               4'b1100: dec_cmd = 4'b0111;
               4'b0001: dec_cmd = 4'b1000;
               4'b1010: begin
                  dec_cmd   = 4'b0100;
                  dec_wb_en = 1'b0;
                  dec_s     = 1'b1;
               end
               4'b1000: begin
                  dec_cmd   = 4'b0110;
                  dec_wb_en = 1'b0;
                  dec_s     = 1'b1;
               end
               default: begin
                  dec_wb_en = 1'b0;
                  dec_s     = 1'b0;
               end
            endcase
         end
         2'b01: begin
            dec_cmd   = 4'b0010;
            dec_mem_r = s_bit;
            dec_wb_en = s_bit;
            dec_mem_w = ~s_bit;
         end
         2'b10: dec_b = 1'b1;
         default: ;
      endcase
   end

   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_ok;
   assign {flag_n, flag_z, flag_c, flag_v} = status;

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         4'b0000: cond_ok = flag_z;
         4'b0001: cond_ok = ~flag_z;
         4'b0010: cond_ok = flag_c;
         4'b0011: cond_ok = ~flag_c;
         4'b0100: cond_ok = flag_n;
         4'b0101: cond_ok = ~flag_n;
         4'b0110: cond_ok = flag_v;
         4'b0111: cond_ok = ~flag_v;
         4'b1000: cond_ok = flag_c & ~flag_z;
         4'b1001: cond_ok = ~flag_c | flag_z;
         4'b1010: cond_ok = (flag_n == flag_v);
         4'b1011: cond_ok = (flag_n != flag_v);
         4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ok = flag_z | (flag_n != flag_v);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   assign id_ready = ~hazard;
   assign src1     = rn;
   assign src2     = dec_mem_w ? rd : rm;
   assign two_src  = ~imm_bit | dec_mem_w;

   // One flop word per register so each can carry its own reset value.
   logic [DATA_W-1:0] rf_word [16];

   for (genvar gi = 0; gi < 16; gi++) begin : g_rf
      localparam logic [DATA_W-1:0] INIT_VAL = (RF_INIT_INDEX != 0) ? DATA_W'(gi) : '0;
      logic [DATA_W-1:0] word_reg;
      always_ff @(posedge clk) begin
         if (rst)
            word_reg <= INIT_VAL;
         else if (wb_en && (wb_dest == 4'(gi)))
            word_reg <= wb_value;
      end
      assign rf_word[gi] = word_reg;
   end

   logic [DATA_W-1:0] rd1_val;
   logic [DATA_W-1:0] rd2_val;
   assign rd1_val = ((WB_BYPASS != 0) && wb_en && (wb_dest == src1)) ? wb_value : rf_word[src1];
   assign rd2_val = ((WB_BYPASS != 0) && wb_en && (wb_dest == src2)) ? wb_value : rf_word[src2];

   ex_t ex_reg;
   ex_t ex_next;

   // Flush, hazard and an empty slot all collapse to the same all-zero bubble.
   always_comb begin
      ex_next = '0;
      if (!flush && !hazard && if_valid) begin
         ex_next.valid    = 1'b1;
         ex_next.pc       = if_pc;
         ex_next.cmd      = cond_ok ? dec_cmd : 4'b0000;
         ex_next.mem_r    = cond_ok & dec_mem_r;
         ex_next.mem_w    = cond_ok & dec_mem_w;
         ex_next.wb_en    = cond_ok & dec_wb_en;
         ex_next.b        = cond_ok & dec_b;
         ex_next.s        = cond_ok & dec_s;
         ex_next.rn_val   = rd1_val;
         ex_next.rm_val   = rd2_val;
         ex_next.imm      = imm_bit;
         ex_next.shift_op = if_instr[11:0];
         ex_next.simm24   = if_instr[23:0];
         ex_next.dest     = rd;
         ex_next.src1     = src1;
         ex_next.src2     = src2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ex_reg <= '0;
      else
         ex_reg <= ex_next;
   end

   assign ex_valid    = ex_reg.valid;
   assign ex_pc       = ex_reg.pc;
   assign ex_cmd      = ex_reg.cmd;
   assign ex_mem_r    = ex_reg.mem_r;
   assign ex_mem_w    = ex_reg.mem_w;
   assign ex_wb_en    = ex_reg.wb_en;
   assign ex_b        = ex_reg.b;
   assign ex_s        = ex_reg.s;
   assign ex_rn_val   = ex_reg.rn_val;
   assign ex_rm_val   = ex_reg.rm_val;
   assign ex_imm      = ex_reg.imm;
   assign ex_shift_op = ex_reg.shift_op;
   assign ex_simm24   = ex_reg.simm24;
   assign ex_dest     = ex_reg.dest;
   assign ex_src1     = ex_reg.src1;
   assign ex_src2     = ex_reg.src2;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: instance 0 has write-back bypass, instance 1 does not.
// Directed vector table, hand-written stall/flush/reset sequences, then random traffic.
module tb_id_stage_pipe;

   localparam int DW = 32;
   localparam int PW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, if_valid, hazard, flush, wb_en;
   logic [PW-1:0] if_pc;
   logic [31:0]   if_instr;
   logic [3:0]    status, wb_dest;
   logic [DW-1:0] wb_value;

   logic          id_ready [2];
   logic [3:0]    src1 [2];
   logic [3:0]    src2 [2];
   logic          two_src [2];
   logic          ex_valid [2];
   logic [PW-1:0] ex_pc [2];
   logic [3:0]    ex_cmd [2];
   logic          ex_mem_r [2];
   logic          ex_mem_w [2];
   logic          ex_wb_en [2];
   logic          ex_b [2];
   logic          ex_s [2];
   logic [DW-1:0] ex_rn_val [2];
   logic [DW-1:0] ex_rm_val [2];
   logic          ex_imm [2];
   logic [11:0]   ex_shift_op [2];
   logic [23:0]   ex_simm24 [2];
   logic [3:0]    ex_dest [2];
   logic [3:0]    ex_src1 [2];
   logic [3:0]    ex_src2 [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      id_stage_pipe #(
         .DATA_W(DW), .PC_W(PW), .WB_BYPASS(gi == 0 ? 1 : 0), .RF_INIT_INDEX(1)
      ) dut (
         .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
         .hazard(hazard), .flush(flush), .status(status),
         .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
         .id_ready(id_ready[gi]), .src1(src1[gi]), .src2(src2[gi]), .two_src(two_src[gi]),
         .ex_valid(ex_valid[gi]), .ex_pc(ex_pc[gi]), .ex_cmd(ex_cmd[gi]),
         .ex_mem_r(ex_mem_r[gi]), .ex_mem_w(ex_mem_w[gi]), .ex_wb_en(ex_wb_en[gi]),
         .ex_b(ex_b[gi]), .ex_s(ex_s[gi]),
         .ex_rn_val(ex_rn_val[gi]), .ex_rm_val(ex_rm_val[gi]), .ex_imm(ex_imm[gi]),
         .ex_shift_op(ex_shift_op[gi]), .ex_simm24(ex_simm24[gi]), .ex_dest(ex_dest[gi]),
         .ex_src1(ex_src1[gi]), .ex_src2(ex_src2[gi])
      );
   end

   typedef struct packed {
      logic          valid;
      logic [PW-1:0] pc;
      logic [3:0]    cmd;
      logic          mr, mw, we, b, s;
      logic [DW-1:0] rn, rm;
      logic          imm;
      logic [11:0]   sh;
      logic [23:0]   simm;
      logic [3:0]    dest, s1, s2;
   } ex_t;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  status;
      logic        wbe;
      logic [3:0]  wbd;
      logic [31:0] wbv;
      logic        xv;
      logic [3:0]  cmd;
      logic        we, mw;
      logic [31:0] rn, rm, rn_nb, rm_nb;
      logic [3:0]  s2;
      logic        two;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] rf_m [16];
   logic [4:0]  op_tab [16];   // {defined, alu command} per data-processing opcode

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Conditions come in complementary pairs: cond[3:1] picks a predicate, cond[0] inverts it.
   function automatic logic pass_m(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, p;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: p = z;
         3'd1: p = cf;
         3'd2: p = n;
         3'd3: p = v;
         3'd4: p = cf & ~z;
         3'd5: p = (n == v);
         3'd6: p = ~z & (n == v);
         default: p = 1'b1;
      endcase
      return p ^ c[0];
   endfunction

   function automatic logic [31:0] rd_m(input logic [3:0] a, input bit byp);
      return (byp && wb_en && wb_dest == a) ? wb_value : rf_m[a];
   endfunction

   function automatic logic is_store();
      return (if_instr[27:26] == 2'b01) && !if_instr[20];
   endfunction

   function automatic logic [3:0] src2_m();
      return is_store() ? if_instr[15:12] : if_instr[3:0];
   endfunction

   function automatic logic [9:0] comb_m();
      return {~hazard, if_instr[19:16], src2_m(), ~if_instr[25] | is_store()};
   endfunction

   function automatic ex_t model(input bit byp);
      ex_t e;
      logic [1:0] mode;
      logic [3:0] op;
      e = '0;
      if (rst || flush || hazard || !if_valid) return e;
      mode = if_instr[27:26];
      op   = if_instr[24:21];
      if (mode == 2'b00 && op_tab[op][4]) begin
         e.cmd = op_tab[op][3:0];
         e.we  = !(op == 4'hA || op == 4'h8);
         e.s   = e.we ? if_instr[20] : 1'b1;
      end else if (mode == 2'b01) begin
         e.cmd = 4'b0010;
         e.mr  = if_instr[20];
         e.we  = if_instr[20];
         e.mw  = !if_instr[20];
      end else if (mode == 2'b10) begin
         e.b = 1'b1;
      end
      if (!pass_m(if_instr[31:28], status)) begin
         e.cmd = '0; e.mr = 0; e.mw = 0; e.we = 0; e.b = 0; e.s = 0;
      end
      e.valid = 1'b1;
      e.pc    = if_pc;
      e.rn    = rd_m(if_instr[19:16], byp);
      e.rm    = rd_m(src2_m(), byp);
      e.imm   = if_instr[25];
      e.sh    = if_instr[11:0];
      e.simm  = if_instr[23:0];
      e.dest  = if_instr[15:12];
      e.s1    = if_instr[19:16];
      e.s2    = src2_m();
      return e;
   endfunction

   function automatic ex_t act_m(input int k);
      return {ex_valid[k], ex_pc[k], ex_cmd[k], ex_mem_r[k], ex_mem_w[k], ex_wb_en[k],
              ex_b[k], ex_s[k], ex_rn_val[k], ex_rm_val[k], ex_imm[k], ex_shift_op[k],
              ex_simm24[k], ex_dest[k], ex_src1[k], ex_src2[k]};
   endfunction

   // Inputs are set at the falling edge; this checks combinational outputs, clocks once,
   // checks the ID/EXE register of both instances and returns at the next falling edge.
   task automatic cycle(input string tag);
      ex_t e0, e1;
      #1;
      for (int k = 0; k < 2; k++)
         chk({tag, "/comb"}, {id_ready[k], src1[k], src2[k], two_src[k]}, comb_m());
      e0 = model(1'b1);
      e1 = model(1'b0);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) rf_m[i] = 32'(i);
      end else if (wb_en) begin
         rf_m[wb_dest] = wb_value;
      end
      #1;
      chk({tag, "/ex_byp"}, act_m(0), e0);
      chk({tag, "/ex_nobyp"}, act_m(1), e1);
      @(negedge clk);
   endtask

   vec_t vt [7];

   initial begin
      for (int i = 0; i < 16; i++) op_tab[i] = 5'h00;
      op_tab[4'hD] = 5'h11; op_tab[4'hF] = 5'h19; op_tab[4'h4] = 5'h12;
      op_tab[4'h5] = 5'h13; op_tab[4'h2] = 5'h14; op_tab[4'h6] = 5'h15;
      op_tab[4'h0] = 5'h16; op_tab[4'hC] = 5'h17; op_tab[4'h1] = 5'h18;
      op_tab[4'hA] = 5'h14; op_tab[4'h8] = 5'h16;

      //         instr         st    wbe wbd   wbv    xv cmd   we mw rn     rm     rn_nb  rm_nb  s2    two
      vt[0] = '{32'hE0802001, 4'h0, 0, 4'h0, 32'h0,  1, 4'h2, 1, 0, 32'h0, 32'h1, 32'h0, 32'h1, 4'h1, 1};
      vt[1] = '{32'hE0802001, 4'h0, 1, 4'h1, 32'h55, 1, 4'h2, 1, 0, 32'h0, 32'h55, 32'h0, 32'h1, 4'h1, 1};
      vt[2] = '{32'h00802001, 4'h0, 0, 4'h0, 32'h0,  1, 4'h0, 0, 0, 32'h0, 32'h55, 32'h0, 32'h55, 4'h1, 1};
      vt[3] = '{32'h00802001, 4'h4, 0, 4'h0, 32'h0,  1, 4'h2, 1, 0, 32'h0, 32'h55, 32'h0, 32'h55, 4'h1, 1};
      vt[4] = '{32'hE5812000, 4'h0, 0, 4'h0, 32'h0,  1, 4'h2, 0, 1, 32'h55, 32'h2, 32'h55, 32'h2, 4'h2, 1};
      vt[5] = '{32'hE3A03005, 4'h0, 1, 4'h0, 32'h77, 1, 4'h1, 1, 0, 32'h77, 32'h5, 32'h0, 32'h5, 4'h5, 0};
      vt[6] = '{32'hE1500001, 4'h0, 0, 4'h0, 32'h0,  1, 4'h4, 0, 0, 32'h77, 32'h55, 32'h77, 32'h55, 4'h1, 1};

      rst = 1; if_valid = 0; if_pc = '0; if_instr = '0; hazard = 0; flush = 0;
      status = '0; wb_en = 0; wb_dest = '0; wb_value = '0;
      @(negedge clk);
      cycle("reset");
      wb_en = 1; wb_dest = 4'h3; wb_value = 32'hDEAD;   // write during reset must be ignored
      cycle("reset_wr");
      chk("reset_valid", ex_valid[0], 1'b0);
      rst = 0; wb_en = 0;

      for (int i = 0; i < 7; i++) begin
         if_valid = 1; if_instr = vt[i].instr; status = vt[i].status; if_pc = 32'h100 + 32'(4 * i);
         wb_en = vt[i].wbe; wb_dest = vt[i].wbd; wb_value = vt[i].wbv;
         cycle($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_src2", i), {src2[0], two_src[0]}, {vt[i].s2, vt[i].two});
         chk($sformatf("vec%0d_ctl", i), {ex_valid[0], ex_cmd[0], ex_wb_en[0], ex_mem_w[0]},
             {vt[i].xv, vt[i].cmd, vt[i].we, vt[i].mw});
         chk($sformatf("vec%0d_byp", i), {ex_rn_val[0], ex_rm_val[0]}, {vt[i].rn, vt[i].rm});
         chk($sformatf("vec%0d_nobyp", i), {ex_rn_val[1], ex_rm_val[1]}, {vt[i].rn_nb, vt[i].rm_nb});
      end

      // Two-cycle stall with a valid ADD waiting, then release.
      if_instr = 32'hE0802001; status = 4'h0; wb_en = 0; hazard = 1; if_pc = 32'h200;
      for (int i = 0; i < 2; i++) begin
         cycle("stall");
         chk("stall_ready", id_ready[0], 1'b0);
         chk("stall_valid", ex_valid[0], 1'b0);
      end
      hazard = 0;
      cycle("release");
      chk("release_ex", {ex_valid[0], ex_cmd[0], ex_pc[0], ex_rm_val[0]}, {1'b1, 4'h2, 32'h200, 32'h55});

      flush = 1; hazard = 1;
      cycle("flush_hazard");
      chk("flush_valid", ex_valid[0], 1'b0);
      flush = 0; hazard = 0;
      cycle("refill");
      rst = 1;
      cycle("mid_reset");
      chk("mid_reset_ex", {ex_valid[0], ex_pc[0], ex_cmd[0], ex_rm_val[0], ex_dest[0]}, '0);
      rst = 0;

      for (int n = 0; n < 600; n++) begin
         rst      = ($urandom_range(0, 59) == 0);
         flush    = ($urandom_range(0, 7) == 0);
         hazard   = ($urandom_range(0, 5) == 0);
         if_valid = ($urandom_range(0, 4) != 0);
         if_instr = $urandom;
         if ($urandom_range(0, 1) == 1) if_instr[31:28] = 4'hE;
         if_pc    = $urandom;
         status   = 4'($urandom);
         wb_en    = $urandom_range(0, 1) == 1;
         wb_value = $urandom;
         case ($urandom_range(0, 2))
            0: wb_dest = if_instr[19:16];
            1: wb_dest = src2_m();
            default: wb_dest = 4'($urandom);
         endcase
         cycle($sformatf("rand%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

- Parametrised instruction-decode stage for the 5-stage ARM-subset pipeline. Sits between IF and EXE.
- Decodes the 32-bit instruction and evaluates its condition against the status flags.
- Contains the 16-entry register file, with optional write-back bypass on reads.
- Registers everything into an ID/EXE pipeline register that supports bubble insertion (hazard) and flush (taken branch).

## Interface
Parameters:
- DATA_W, 32, register-file and operand width
- PC_W, 32, program-counter width
- WB_BYPASS, 1, 1: same-cycle write-back value forwarded to reads; 0: reads return stored value
- RF_INIT_INDEX, 1, 1: on reset register i = i (zero-extended); 0: all registers reset to 0

Ports:
- clk  in  1  rising-edge clock, sole clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  IF presents a valid instruction
- if_pc  in  PC_W  PC+4 of the instruction
- if_instr  in  32  instruction word
- hazard  in  1  stall request from the hazard unit
- flush  in  1  taken-branch flush from EXE
- status  in  4  flags {N,Z,C,V}
- wb_en  in  1  write-back enable
- wb_dest  in  4  write-back register index
- wb_value  in  DATA_W  write-back data
- id_ready  out  1  combinational; equals ~hazard
- src1, src2  out  4 each  combinational source indices, for the hazard unit
- two_src  out  1  combinational; the instruction reads two registers
- ex_valid  out  1  registered; ID/EXE holds a real instruction
- ex_pc  out  PC_W  registered
- ex_cmd  out  4  registered ALU command
- ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s  out  1 each  registered control bits
- ex_rn_val, ex_rm_val  out  DATA_W each  registered operand values
- ex_imm  out  1  registered
- ex_shift_op  out  12  registered
- ex_simm24  out  24  registered
- ex_dest  out  4  registered destination index
- ex_src1, ex_src2  out  4 each  registered source indices, for forwarding

## Operation
Instruction fields:
- cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shift_op[11:0], Rm[3:0]
- simm24 = if_instr[23:0]

Decode, mode 00 (data processing). opcode → cmd:
- MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101
- AND 0000→0110, ORR 1100→0111, EOR 0001→1000
- CMP 1010→0100, TST 1000→0110; these two force wb_en=0 and s=1
- For all others: wb_en=1, s=S
- Undefined opcodes: all controls 0

Decode, mode 01 (memory):
- S=1 is LDR: cmd 0010, mem_r=1, wb_en=1
- S=0 is STR: cmd 0010, mem_w=1
- s=0 in both cases

Decode, mode 10: b=1, all other controls 0. Mode 11: all controls 0.

Condition check, pass when:
- EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V
- HI C&~Z, LS ~C|Z
- GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V)
- AL always; 1111 never

Sources:
- src1 = Rn
- src2 = mem_w ? Rd : Rm
- two_src = ~I | mem_w

Register file:
- 16 × DATA_W.
- Write on the rising edge when wb_en.
- Two combinational reads at src1 and src2.
- With WB_BYPASS=1, a read whose address equals wb_dest while wb_en=1 returns wb_value. This applies to R0 too; there is no hard-wired zero register.

ID/EXE register update, in priority order each rising edge:
1. rst: ex_valid=0 and every ex_* output is 0. Register file is initialised per RF_INIT_INDEX.
2. flush: bubble.
3. hazard: bubble.
4. ~if_valid: bubble.
5. Condition fails: capture all data fields, ex_valid=1, all five control bits and ex_cmd forced to 0.
6. Otherwise: capture decoded controls and all fields, ex_valid=1.

A bubble means ex_valid=0 and all ex_* outputs are 0.

## Timing
- Decode, condition check and register read are combinational within the cycle.
- Latency is one cycle from if_instr to ex_* outputs.
- Register-file write and the ID/EXE capture happen on the same edge:
  - WB_BYPASS=1: an instruction reading the register being written captures wb_value.
  - WB_BYPASS=0: it captures the old value.
- id_ready follows hazard combinationally.
  - IF must hold if_pc/if_instr while id_ready=0.
  - The block itself holds no copy of the stalled instruction.
- flush and hazard asserted together produce a single bubble; flush wins.
- A write during rst is ignored, because reset re-initialises the register file.
- After rst is deasserted, the first capture occurs on the next edge.

## Test plan
- Reset with RF_INIT_INDEX=1, then present 0xE0802001 (ADD R2,R0,R1) with if_valid=1. Next cycle: ex_valid=1, ex_cmd=0010, ex_wb_en=1, ex_rn_val=0, ex_rm_val=1, ex_dest=2.
- Same instruction with wb_en=1, wb_dest=1, wb_value=0x55 in the same cycle. Expect ex_rm_val=0x55 with WB_BYPASS=1, and 1 with WB_BYPASS=0.
- 0x00802001 (ADDEQ) with status=0000: ex_valid=1 and all controls 0. With status=0100: ex_wb_en=1, ex_cmd=0010.
- 0xE5812000 (STR R2,[R1]): two_src=1, src2=2, ex_mem_w=1, ex_wb_en=0, ex_rm_val = contents of R2.
- hazard=1 for 2 cycles with a valid ADD present: id_ready=0 and ex_valid=0 both cycles. On release, the ADD appears in ex_* one cycle later.
- flush=1 and hazard=1 simultaneously: ex_valid=0. Assert rst while ex_valid=1: ex_valid=0 and every ex_* output is 0 next cycle.
